// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access issuer: funct3 opcodes, FSM states,
// CSR address field positions and the decode result bundle.
package csr_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // addr[11:10]==2'b11 marks a read-only CSR, addr[9:8] the lowest privilege allowed
  localparam int CSR_RO_HI   = 11;
  localparam int CSR_RO_LO   = 10;
  localparam int CSR_PRIV_HI = 9;
  localparam int CSR_PRIV_LO = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } issuer_state_e;

  typedef struct packed {
    logic is_rw;
    logic is_rs;
    logic is_rc;
    logic use_imm;
    logic do_write;
    logic illegal;
  } csr_dec_t;

endpackage

// File: rtl/csr_access_issuer_if.sv
// Issue-stage request and writeback response channels of the CSR access issuer.
interface csr_access_issuer_if #(
  parameter int DW = 64
);
  logic          issue_valid;
  logic          issue_ready;
  logic [2:0]    issue_funct3;
  logic [11:0]   issue_addr;
  logic [DW-1:0] issue_rs1_data;
  logic [4:0]    issue_rs1_idx;
  logic [4:0]    issue_rd;

  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_illegal;

  modport master (
    output issue_valid, issue_funct3, issue_addr, issue_rs1_data, issue_rs1_idx, issue_rd,
    output wb_ready,
    input  issue_ready, wb_valid, wb_rd, wb_data, wb_illegal
  );

  modport slave (
    input  issue_valid, issue_funct3, issue_addr, issue_rs1_data, issue_rs1_idx, issue_rd,
    input  wb_ready,
    output issue_ready, wb_valid, wb_rd, wb_data, wb_illegal
  );
endinterface

// File: rtl/csr_op_decode.sv
// Combinational CSR instruction decode: operation class, write intent and
// illegal-instruction detection for the latched instruction.
module csr_op_decode
  import csr_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1_idx,
  input  logic [11:0] addr,
  input  logic [1:0]  priv,
  output csr_dec_t    dec
);

  logic valid_op;
  logic ro_csr;
  logic priv_fail;

  always_comb begin
    dec = '0;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: dec.is_rw = 1'b1;
      F3_CSRRS, F3_CSRRSI: dec.is_rs = 1'b1;
      F3_CSRRC, F3_CSRRCI: dec.is_rc = 1'b1;
      default: ;
    endcase
    dec.use_imm  = funct3[2];
    // set/clear with x0 / zimm 0 is a pure read; swap always writes
    dec.do_write = dec.is_rw | ((dec.is_rs | dec.is_rc) & (rs1_idx != 5'd0));
    valid_op     = dec.is_rw | dec.is_rs | dec.is_rc;
    ro_csr       = (addr[CSR_RO_HI:CSR_RO_LO] == 2'b11);
    priv_fail    = (addr[CSR_PRIV_HI:CSR_PRIV_LO] > priv);
    dec.illegal  = !valid_op | priv_fail | (ro_csr & dec.do_write);
  end

endmodule

// File: rtl/csr_access_issuer.sv
// Single-outstanding CSR requester: latches one instruction, reads the old value,
// fires a one-cycle write strobe and returns the old value to writeback.
module csr_access_issuer
  import csr_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  csr_access_issuer_if.slave   bus,
  input  logic [1:0]           priv,
  input  logic                 flush,
  output logic [11:0]          csr_raddr,
  input  logic [DW-1:0]        csr_rdata,
  output logic [DW-1:0]        csr_op,
  output logic [11:0]          addr,
  output logic                 rw,
  output logic                 rs,
  output logic                 rc
);

  issuer_state_e state;

  logic [2:0]    f3_q;
  logic [11:0]   addr_q;
  logic [DW-1:0] rs1_q;
  logic [4:0]    idx_q;
  logic [4:0]    rd_q;

  csr_dec_t      dec;
  logic [DW-1:0] operand;
  logic          wr;

  csr_op_decode u_dec (
    .funct3  (f3_q),
    .rs1_idx (idx_q),
    .addr    (addr_q),
    .priv    (priv),
    .dec     (dec)
  );

  assign operand = dec.use_imm ? {{(DW-5){1'b0}}, idx_q} : rs1_q;
  assign wr      = dec.do_write & ~dec.illegal;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state          <= IDLE;
      f3_q           <= '0;
      addr_q         <= '0;
      rs1_q          <= '0;
      idx_q          <= '0;
      rd_q           <= '0;
      csr_raddr      <= '0;
      csr_op         <= '0;
      addr           <= '0;
      rw             <= 1'b0;
      rs             <= 1'b0;
      rc             <= 1'b0;
      bus.issue_ready <= 1'b1;
      bus.wb_valid   <= 1'b0;
      bus.wb_rd      <= '0;
      bus.wb_data    <= '0;
      bus.wb_illegal <= 1'b0;
    end else begin
      // strobes live for exactly one cycle; a later state sets them again if needed
      rw     <= 1'b0;
      rs     <= 1'b0;
      rc     <= 1'b0;
      addr   <= '0;
      csr_op <= '0;
      case (state)
        IDLE: begin
          if (bus.issue_valid) begin
            f3_q            <= bus.issue_funct3;
            addr_q          <= bus.issue_addr;
            rs1_q           <= bus.issue_rs1_data;
            idx_q           <= bus.issue_rs1_idx;
            rd_q            <= bus.issue_rd;
            csr_raddr       <= bus.issue_addr;
            bus.issue_ready <= 1'b0;
            state           <= READ;
          end
        end
        READ: begin
          csr_raddr <= '0;
          if (flush) begin
            bus.issue_ready <= 1'b1;
            state           <= IDLE;
          end else begin
            rw             <= wr & dec.is_rw;
            rs             <= wr & dec.is_rs;
            rc             <= wr & dec.is_rc;
            addr           <= wr ? addr_q : 12'd0;
            csr_op         <= wr ? operand : '0;
            bus.wb_valid   <= 1'b1;
            bus.wb_rd      <= rd_q;
            bus.wb_data    <= dec.illegal ? '0 : csr_rdata;
            bus.wb_illegal <= dec.illegal;
            state          <= RESP;
          end
        end
        RESP: begin
          // a strobe already on the bus this cycle still commits; flush only drops the response
          if (flush || bus.wb_ready) begin
            bus.wb_valid    <= 1'b0;
            bus.wb_rd       <= '0;
            bus.wb_data     <= '0;
            bus.wb_illegal  <= 1'b0;
            bus.issue_ready <= 1'b1;
            state           <= IDLE;
          end
        end
        default: begin
          bus.issue_ready <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

  a_strobe_onehot: assert property (@(posedge CLK) disable iff (!RSTn) $onehot0({rw, rs, rc}));
  a_bus_quiet:     assert property (@(posedge CLK) disable iff (!RSTn)
                                    !(rw | rs | rc) |-> (addr == 12'd0 && csr_op == '0));

endmodule

// File: tb/tb_csr_access_issuer.sv
// Scoreboard bench for csr_access_issuer: expected writeback results are queued
// at issue time and compared when the response handshake completes.
module tb_csr_access_issuer;
  localparam int DW = 64;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
    logic          ill;
  } wb_t;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic [1:0]    priv = 2'd3;
  logic          flush = 1'b0;
  logic [11:0]   csr_raddr;
  logic [DW-1:0] csr_rdata;
  logic [DW-1:0] csr_op;
  logic [11:0]   addr;
  logic          rw, rs, rc;

  logic [11:0]   cur_addr = 12'h0;
  logic [DW-1:0] cur_val  = '0;

  csr_access_issuer_if #(.DW(DW)) bus ();

  csr_access_issuer #(.DW(DW)) dut (
    .CLK(CLK), .RSTn(RSTn), .bus(bus), .priv(priv), .flush(flush),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_op(csr_op),
    .addr(addr), .rw(rw), .rs(rs), .rc(rc)
  );

  always #5 CLK = ~CLK;

  // bank model: only the addressed CSR returns its value
  always_comb csr_rdata = (csr_raddr == cur_addr) ? cur_val : 64'hBAD0_BAD0_BAD0_BAD0;

  int checks = 0;
  int errors = 0;

  wb_t exp_q[$];
  wb_t obs_q[$];

  int            n_strobe, s_cyc, wbv_cyc, hs_cyc;
  logic [2:0]    s_kind;
  logic [11:0]   s_addr;
  logic [DW-1:0] s_op;
  bit rdy_bad, wb_unstable, bus_bad, timeout, wb_dropped, ready_at2, ready_after, accept_rdy;

  task automatic run_instr(input logic [2:0] f3, input logic [11:0] a, input logic [DW-1:0] d,
                           input logic [4:0] idx, input logic [4:0] rd, input logic [DW-1:0] rv,
                           input int hold, input int flush_at);
    int  cyc;
    bit  done;
    wb_t first;
    cur_addr = a; cur_val = rv;
    n_strobe = 0; s_kind = 0; s_addr = 0; s_op = 0; s_cyc = -1; wbv_cyc = -1; hs_cyc = -1;
    rdy_bad = 0; wb_unstable = 0; bus_bad = 0; timeout = 0; wb_dropped = 0; ready_at2 = 0;
    first = '0;
    @(negedge CLK);
    accept_rdy = bus.issue_ready;
    bus.issue_funct3 = f3; bus.issue_addr = a; bus.issue_rs1_data = d;
    bus.issue_rs1_idx = idx; bus.issue_rd = rd; bus.issue_valid = 1'b1;
    @(posedge CLK); #1;
    bus.issue_valid = 1'b0;
    cyc = 1; done = 0;
    while (!done) begin
      flush = (cyc == flush_at);
      @(negedge CLK);
      if (rw | rs | rc) begin
        n_strobe++; s_kind = {rw, rs, rc}; s_addr = addr; s_op = csr_op; s_cyc = cyc;
      end else if (addr != 12'd0 || csr_op != '0) bus_bad = 1;
      if (cyc == 2) ready_at2 = bus.issue_ready;
      if (bus.wb_valid) begin
        if (bus.issue_ready) rdy_bad = 1;
        if (wbv_cyc < 0) begin
          wbv_cyc = cyc; first = '{bus.wb_rd, bus.wb_data, bus.wb_illegal};
        end else if (wb_t'{bus.wb_rd, bus.wb_data, bus.wb_illegal} !== first) wb_unstable = 1;
        if (cyc - wbv_cyc >= hold) begin
          bus.wb_ready = 1'b1; hs_cyc = cyc; obs_q.push_back(first); done = 1;
        end
      end else begin
        if (cyc == 1 && bus.issue_ready) rdy_bad = 1;
        if (wbv_cyc >= 0) wb_dropped = 1;
        if (cyc >= 2) done = 1;
      end
      if (!done && cyc >= 30) begin timeout = 1; done = 1; end
      if (!done) begin @(posedge CLK); #1; cyc++; end
    end
    @(posedge CLK); #1;
    bus.wb_ready = 1'b0; flush = 1'b0;
    @(negedge CLK);
    ready_after = bus.issue_ready;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.issue_ready !== 1'b1 || bus.wb_valid !== 1'b0 || {rw, rs, rc} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: ready=%b wb_valid=%b strobes=%b, want 1 0 000",
                         bus.issue_ready, bus.wb_valid, {rw, rs, rc});
    end
    checks++;
    if (addr !== 12'd0 || csr_op !== '0 || csr_raddr !== 12'd0 || bus.wb_data !== '0 ||
        bus.wb_rd !== 5'd0 || bus.wb_illegal !== 1'b0) begin
      errors++; $display("FAIL reset_data: addr=%h op=%h raddr=%h wb_data=%h rd=%0d ill=%b, want all 0",
                         addr, csr_op, csr_raddr, bus.wb_data, bus.wb_rd, bus.wb_illegal);
    end
    RSTn = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: ready=%b want 1", bus.issue_ready);
    end
  endtask

  task automatic test_rw();
    wb_t e, o;
    priv = 2'd3;
    exp_q.push_back('{5'd7, 64'h1234, 1'b0});
    run_instr(3'b001, 12'h340, 64'hDEAD, 5'd3, 5'd7, 64'h1234, 0, -1);
    checks++;
    if (n_strobe !== 1 || s_kind !== 3'b100 || s_addr !== 12'h340 || s_op !== 64'hDEAD || s_cyc !== 2) begin
      errors++; $display("FAIL rw_strobe: n=%0d kind=%b addr=%h op=%h cyc=%0d, want 1 100 340 dead 2",
                         n_strobe, s_kind, s_addr, s_op, s_cyc);
    end
    checks++;
    if (wbv_cyc !== 2 || rdy_bad || bus_bad || timeout || !ready_after) begin
      errors++; $display("FAIL rw_timing: wbv_cyc=%0d rdy_bad=%b bus_bad=%b timeout=%b ready_after=%b, want 2 0 0 0 1",
                         wbv_cyc, rdy_bad, bus_bad, timeout, ready_after);
    end
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL rw_wb: no response, want rd=7 data=1234");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin
        errors++; $display("FAIL rw_wb: got rd=%0d data=%h ill=%b, want rd=%0d data=%h ill=%b",
                           o.rd, o.data, o.ill, e.rd, e.data, e.ill);
      end
    end
  endtask

  task automatic test_rs_noop();
    wb_t e, o;
    exp_q.push_back('{5'd9, 64'hCAFE, 1'b0});
    run_instr(3'b010, 12'h300, 64'hFFFF, 5'd0, 5'd9, 64'hCAFE, 0, -1);
    checks++;
    if (n_strobe !== 0 || bus_bad) begin
      errors++; $display("FAIL rs_nostrobe: n=%0d bus_bad=%b, want 0 0", n_strobe, bus_bad);
    end
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL rs_wb: no response, want data=cafe");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin
        errors++; $display("FAIL rs_wb: got rd=%0d data=%h ill=%b, want rd=%0d data=%h ill=%b",
                           o.rd, o.data, o.ill, e.rd, e.data, e.ill);
      end
    end
  endtask

  task automatic test_rci();
    wb_t e, o;
    exp_q.push_back('{5'd1, 64'h80, 1'b0});
    run_instr(3'b111, 12'h344, 64'hFFFF_FFFF_FFFF_FFFF, 5'h1F, 5'd1, 64'h80, 0, -1);
    checks++;
    if (n_strobe !== 1 || s_kind !== 3'b001 || s_addr !== 12'h344 || s_op !== 64'h1F || s_cyc !== 2) begin
      errors++; $display("FAIL rci_strobe: n=%0d kind=%b addr=%h op=%h cyc=%0d, want 1 001 344 1f 2",
                         n_strobe, s_kind, s_addr, s_op, s_cyc);
    end
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL rci_wb: no response");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin
        errors++; $display("FAIL rci_wb: got rd=%0d data=%h ill=%b, want rd=%0d data=%h ill=%b",
                           o.rd, o.data, o.ill, e.rd, e.data, e.ill);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0]  f3s  [5] = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b010};
    logic [11:0] as   [5] = '{12'hC00, 12'h300, 12'h340, 12'h340, 12'hC00};
    logic [1:0]  ps   [5] = '{2'd3, 2'd0, 2'd3, 2'd3, 2'd3};
    logic [4:0]  idxs [5] = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd0};
    bit          ills [5] = '{1, 1, 1, 1, 0};
    wb_t e, o;
    for (int i = 0; i < 5; i++) begin
      priv = ps[i];
      exp_q.push_back('{5'(10 + i), ills[i] ? 64'h0 : 64'h5A5A, ills[i]});
      run_instr(f3s[i], as[i], 64'h77, idxs[i], 5'(10 + i), 64'h5A5A, 0, -1);
      checks++;
      if (n_strobe !== 0) begin
        errors++; $display("FAIL illegal_strobe[%0d]: n=%0d kind=%b, want 0", i, n_strobe, s_kind);
      end
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL illegal_wb[%0d]: no response", i);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL illegal_wb[%0d]: got rd=%0d data=%h ill=%b, want rd=%0d data=%h ill=%b",
                             i, o.rd, o.data, o.ill, e.rd, e.data, e.ill);
        end
      end
    end
    priv = 2'd3;
  endtask

  task automatic test_flush_read();
    obs_q.delete();
    run_instr(3'b001, 12'h340, 64'h99, 5'd1, 5'd4, 64'h11, 0, 1);
    checks++;
    if (n_strobe !== 0 || wbv_cyc !== -1 || obs_q.size() !== 0) begin
      errors++; $display("FAIL flush_read: strobes=%0d wbv_cyc=%0d resp=%0d, want 0 -1 0",
                         n_strobe, wbv_cyc, obs_q.size());
    end
    checks++;
    if (ready_at2 !== 1'b1) begin
      errors++; $display("FAIL flush_read_ready: ready next cycle=%b want 1", ready_at2);
    end
  endtask

  task automatic test_flush_resp();
    obs_q.delete();
    run_instr(3'b011, 12'h344, 64'hF0, 5'd4, 5'd6, 64'h22, 10, 2);
    checks++;
    if (n_strobe !== 1 || s_kind !== 3'b001 || s_op !== 64'hF0 || s_cyc !== 2) begin
      errors++; $display("FAIL flush_resp_strobe: n=%0d kind=%b op=%h cyc=%0d, want 1 001 f0 2",
                         n_strobe, s_kind, s_op, s_cyc);
    end
    checks++;
    if (!wb_dropped || obs_q.size() !== 0 || !ready_after) begin
      errors++; $display("FAIL flush_resp_wb: dropped=%b resp=%0d ready=%b, want 1 0 1",
                         wb_dropped, obs_q.size(), ready_after);
    end
  endtask

  task automatic test_backpressure();
    wb_t e, o;
    obs_q.delete();
    exp_q.push_back('{5'd12, 64'hABCD_0000_1111_2222, 1'b0});
    run_instr(3'b010, 12'h341, 64'h55, 5'd2, 5'd12, 64'hABCD_0000_1111_2222, 5, -1);
    checks++;
    if (n_strobe !== 1 || s_kind !== 3'b010 || s_cyc !== 2 || s_op !== 64'h55) begin
      errors++; $display("FAIL bp_strobe: n=%0d kind=%b cyc=%0d op=%h, want 1 010 2 55",
                         n_strobe, s_kind, s_cyc, s_op);
    end
    checks++;
    if (wb_unstable || rdy_bad || (hs_cyc - wbv_cyc) !== 5 || timeout) begin
      errors++; $display("FAIL bp_hold: unstable=%b rdy_bad=%b held=%0d timeout=%b, want 0 0 5 0",
                         wb_unstable, rdy_bad, hs_cyc - wbv_cyc, timeout);
    end
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL bp_wb: no response");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin
        errors++; $display("FAIL bp_wb: got rd=%0d data=%h ill=%b, want rd=%0d data=%h ill=%b",
                           o.rd, o.data, o.ill, e.rd, e.data, e.ill);
      end
    end
  endtask

  task automatic test_back_to_back();
    wb_t e, o;
    obs_q.delete();
    exp_q.push_back('{5'd20, 64'h100, 1'b0});
    exp_q.push_back('{5'd21, 64'h200, 1'b0});
    exp_q.push_back('{5'd22, 64'h300, 1'b0});
    run_instr(3'b101, 12'h305, 64'h0, 5'd9, 5'd20, 64'h100, 0, -1);
    checks++;
    if (!accept_rdy || s_kind !== 3'b100 || s_op !== 64'h9) begin
      errors++; $display("FAIL b2b_0: ready=%b kind=%b op=%h, want 1 100 9", accept_rdy, s_kind, s_op);
    end
    run_instr(3'b010, 12'h306, 64'h3C, 5'd8, 5'd21, 64'h200, 0, -1);
    checks++;
    if (!accept_rdy || s_kind !== 3'b010 || s_op !== 64'h3C || s_addr !== 12'h306) begin
      errors++; $display("FAIL b2b_1: ready=%b kind=%b op=%h addr=%h, want 1 010 3c 306",
                         accept_rdy, s_kind, s_op, s_addr);
    end
    run_instr(3'b011, 12'h307, 64'hC3, 5'd8, 5'd22, 64'h300, 0, -1);
    checks++;
    if (!accept_rdy || s_kind !== 3'b001 || s_op !== 64'hC3) begin
      errors++; $display("FAIL b2b_2: ready=%b kind=%b op=%h, want 1 001 c3", accept_rdy, s_kind, s_op);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL b2b_wb[%0d]: missing response (obs=%0d exp=%0d)", i, obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL b2b_wb[%0d]: got rd=%0d data=%h ill=%b, want rd=%0d data=%h ill=%b",
                             i, o.rd, o.data, o.ill, e.rd, e.data, e.ill);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    cur_addr = 12'h340; cur_val = 64'h1;
    @(negedge CLK);
    bus.issue_funct3 = 3'b001; bus.issue_addr = 12'h340; bus.issue_rs1_data = 64'h42;
    bus.issue_rs1_idx = 5'd1; bus.issue_rd = 5'd3; bus.issue_valid = 1'b1;
    @(posedge CLK); #1;
    bus.issue_valid = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (rw !== 1'b1 || bus.wb_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: rw=%b wb_valid=%b, want 1 1", rw, bus.wb_valid);
    end
    RSTn = 1'b0;
    #1;
    checks++;
    if (rw !== 1'b0 || bus.wb_valid !== 1'b0 || bus.issue_ready !== 1'b1 || addr !== 12'd0 || csr_op !== '0) begin
      errors++; $display("FAIL rstmid_async: rw=%b wb_valid=%b ready=%b addr=%h op=%h, want 0 0 1 0 0",
                         rw, bus.wb_valid, bus.issue_ready, addr, csr_op);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    bus.issue_valid = 1'b0; bus.issue_funct3 = '0; bus.issue_addr = '0;
    bus.issue_rs1_data = '0; bus.issue_rs1_idx = '0; bus.issue_rd = '0; bus.wb_ready = 1'b0;
    test_reset();
    test_rw();
    test_rs_noop();
    test_rci();
    test_illegal();
    test_flush_read();
    test_flush_resp();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/csr_access_issuer.md
Name: csr_access_issuer

Overview:
- Requester side of the CSR register bank: accepts one CSR instruction at a time from the issue stage and reads the old CSR value.
- Drives the single-cycle write strobes (addr/csr_op/rw/rs/rc) consumed by every CSR register instance in the bank.
- Returns the old value to writeback through a valid/ready handshake.
- Sits between the CSR issue queue and the CSR register bank; one outstanding access at most.

Parameters:
- DW, 64, CSR and operand data width.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RSTn  input  1  asynchronous active-low reset
- issue_valid  input  1  CSR instruction available
- issue_ready  output  1  block can accept (state IDLE)
- issue_funct3  input  3  instruction funct3
- issue_addr  input  12  CSR address
- issue_rs1_data  input  DW  rs1 operand value
- issue_rs1_idx  input  5  rs1 field (register index, or zimm for immediate forms)
- issue_rd  input  5  destination register
- priv  input  2  current privilege level
- flush  input  1  pipeline flush / abort
- csr_raddr  output  12  read address to bank
- csr_rdata  input  DW  combinational read data from bank
- csr_op  output  DW  write operand to bank
- addr  output  12  write address to bank
- rw  output  1  write strobe
- rs  output  1  set strobe
- rc  output  1  clear strobe
- wb_valid  output  1  result available
- wb_ready  input  1  writeback accepts
- wb_rd  output  5  destination register
- wb_data  output  DW  old CSR value
- wb_illegal  output  1  access raised illegal-instruction

Behaviour:
- Reset: state IDLE; issue_ready=1; all other outputs 0.
- States and transitions:
  - IDLE: issue_ready=1. issue_valid&issue_ready latches funct3, addr, operand, rs1_idx, rd → READ.
  - READ: csr_raddr=latched addr; csr_rdata sampled into old_val at edge. Illegal check evaluated → RESP. If flush: discard, no strobe → IDLE.
  - RESP: wb_valid=1 with wb_rd, wb_data=old_val, wb_illegal. Hold until wb_valid&wb_ready → IDLE. flush → IDLE next cycle, wb_valid deasserted.
- Decode: 001 RW, 010 RS, 011 RC use rs1_data. 101/110/111 use zimm = rs1_idx zero-extended to DW. 000 and 100 are illegal.
- Write suppression: RS/RC(/I) with rs1_idx==0 issue no strobe (pure read). RW(/I) always writes, regardless of rd.
- Illegal when any of:
  - funct3 invalid;
  - addr[9:8] > priv;
  - addr[11:10]==2'b11 and a write would occur.
- On illegal: no strobe, wb_data=0, wb_illegal=1.
- Strobes:
  - Registered, asserted exactly one cycle: the first RESP cycle.
  - At most one of rw/rs/rc high; addr and csr_op valid only while a strobe is high, 0 otherwise.
  - The write commits at the end of that cycle even if flush is high in it; flush cannot retract a presented strobe.
- Latency: accept at cycle 0, read cycle 1, strobe + wb_valid cycle 2; minimum 3 cycles per instruction (no overlap).
- Reset mid-operation: returns to IDLE immediately, strobes and wb_valid drop asynchronously.

Decomposition:
- Shared package csr_pkg:
  - funct3 encodings (CSRRW..CSRRCI);
  - issuer state enum (IDLE/READ/RESP);
  - CSR address field positions (read-only bits [11:10], privilege bits [9:8]).
- One natural combinational sub-module csr_op_decode: funct3 + rs1_idx + addr + priv → {is_rw, is_rs, is_rc, use_imm, do_write, illegal}.

Test Plan:
- CSRRW addr 0x340, rs1_data 0xDEAD, bank returns 0x1234, priv=3 → cycle 2: rw=1, addr=0x340, csr_op=0xDEAD for one cycle; wb_data=0x1234, wb_illegal=0.
- CSRRS addr 0x300, rs1_idx=0 → no strobe in any cycle; wb_data=csr_rdata, wb_illegal=0.
- CSRRCI addr 0x344, zimm=5'h1F → rc=1, csr_op=0x1F zero-extended; exactly one cycle.
- CSRRW addr 0xC00 (read-only) → no strobe, wb_illegal=1, wb_data=0. Repeat with addr 0x300 at priv=0 → illegal.
- flush asserted in READ → no strobe, no wb_valid, issue_ready=1 next cycle.
- Hold wb_ready=0 for 5 cycles in RESP → wb_valid/wb_data stable, strobe only in first RESP cycle, issue_ready=0 throughout.
- Any cycle: more than one of rw/rs/rc high → assertion fails.
